// File: rtl/mem_dump_reader_pkg.sv
// rtl/mem_dump_reader_pkg.sv - shared board-interface definitions for the memory dump reader
package mem_dump_reader_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEFAULT_MAX_BYTES = 1024;
  localparam logic [BYTE_W-1:0] NUL_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

  // Little-endian lane select: lane 0 is the least significant byte.
  function automatic logic [BYTE_W-1:0] word_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [BYTE_W-1:0] b;
    unique case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_dump_reader_if.sv
// rtl/mem_dump_reader_if.sv - memory port 2 read bus and byte stream bundle
interface mem_dump_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output mem_addr, mem_rd_en, byte_data, byte_valid,
    input  mem_rdata, byte_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, byte_data, byte_valid,
    output mem_rdata, byte_ready
  );

endinterface

// File: rtl/mem_dump_unpack.sv
// rtl/mem_dump_unpack.sv - word register and lane counter presenting one byte at a time
module mem_dump_unpack
  import mem_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [31:0]       load_word,
  input  logic              flush,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              xfer,
  output logic              last_xfer
);

  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic        valid_q;

  assign xfer       = valid_q && byte_ready;
  assign last_xfer  = xfer && (lane_q == 2'd3);
  assign byte_valid = valid_q;
  assign byte_data  = word_lane(word_q, lane_q);

  // flush drops valid on the terminating transfer even mid-word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      lane_q  <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      if (flush || lane_q == 2'd3) begin
        valid_q <= 1'b0;
      end else begin
        lane_q <= lane_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - dumps memory bytes from a start address to a byte stream
// MEM_DUMP_NUL_TERM_EN: when defined, a transferred NUL byte ends the dump.
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BYTES   = DEFAULT_MAX_BYTES,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              start_addr,
  mem_dump_reader_if.master              bus,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LAT_W-1:0]  lat_q;
  logic              rd_en_q;
  logic [DATA_W-1:0] rdata_w;
  logic [BYTE_W-1:0] byte_data_w;
  logic              byte_valid_w;
  logic              load, xfer, last_xfer, is_nul, at_limit, terminate, accept;

  assign rdata_w        = bus.mem_rdata;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.byte_data  = byte_data_w;
  assign bus.byte_valid = byte_valid_w;

  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign load      = (state_q == ST_WAIT) && (lat_q == '0);
  assign at_limit  = (byte_count == CNT_W'(MAX_BYTES - 1));
`ifdef MEM_DUMP_NUL_TERM_EN
  assign is_nul    = (byte_data_w == NUL_BYTE);
`else
  assign is_nul    = 1'b0;
`endif
  assign terminate = xfer && (is_nul || at_limit);

  mem_dump_unpack u_unpack (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (rdata_w),
    .flush      (terminate),
    .byte_ready (bus.byte_ready),
    .byte_data  (byte_data_w),
    .byte_valid (byte_valid_w),
    .xfer       (xfer),
    .last_xfer  (last_xfer)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_REQ;
      ST_REQ:           state_d = ST_WAIT;
      ST_WAIT:          if (lat_q == '0) state_d = ST_EMIT;
      ST_EMIT: begin
        if (terminate)      state_d = ST_DONE;
        else if (last_xfer) state_d = ST_REQ;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      lat_q      <= '0;
      rd_en_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= (state_d == ST_REQ);

      if (state_q == ST_REQ) begin
        lat_q <= LAT_W'(MEM_LATENCY - 1);
      end else if (state_q == ST_WAIT && lat_q != '0) begin
        lat_q <= lat_q - LAT_W'(1);
      end

      if (accept) begin
        addr_q     <= start_addr;
        byte_count <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else if (xfer) begin
        byte_count <= byte_count + CNT_W'(1);
      end

      // word address wraps naturally at the top of the address space
      if (terminate) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else if (last_xfer) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - randomized self-checking bench for mem_dump_reader (follows MEM_DUMP_NUL_TERM_EN)
`timescale 1ns/1ps
module tb_mem_dump_reader;
  import mem_dump_reader_pkg::*;

  localparam int MAX_A = 8;
  localparam int LAT_A = 1;
  localparam int MAX_B = 6;
  localparam int LAT_B = 3;
`ifdef MEM_DUMP_NUL_TERM_EN
  localparam bit NUL_EN = 1'b1;
`else
  localparam bit NUL_EN = 1'b0;
`endif

  logic ADC_CLK_10 = 1'b0;
  always #5 ADC_CLK_10 = ~ADC_CLK_10;
  int cyc = 0;
  always @(posedge ADC_CLK_10) cyc <= cyc + 1;

  logic [1:0]  rst, start, ready, valid, rd_en, busy, done;
  logic [31:0] start_addr [2];
  logic [31:0] maddr [2];
  logic [7:0]  bdata [2];
  logic [31:0] bcount [2];
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] pipe_b [3];
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [31:0] mem [2][256];

  mem_dump_reader_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_dump_reader_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  assign bus_a.byte_ready = ready[0];
  assign bus_a.mem_rdata  = rdata_a;
  assign bus_b.byte_ready = ready[1];
  assign bus_b.mem_rdata  = rdata_b;
  assign valid[0] = bus_a.byte_valid;
  assign valid[1] = bus_b.byte_valid;
  assign rd_en[0] = bus_a.mem_rd_en;
  assign rd_en[1] = bus_b.mem_rd_en;
  assign maddr[0] = bus_a.mem_addr;
  assign maddr[1] = bus_b.mem_addr;
  assign bdata[0] = bus_a.byte_data;
  assign bdata[1] = bus_b.byte_data;
  assign bcount[0] = {28'd0, cnt_a};
  assign bcount[1] = {29'd0, cnt_b};

  mem_dump_reader #(.ADDR_W(32), .DATA_W(32), .MAX_BYTES(MAX_A), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(ADC_CLK_10), .rst(rst[0]), .start(start[0]), .start_addr(start_addr[0]),
    .bus(bus_a.master), .busy(busy[0]), .done(done[0]), .byte_count(cnt_a));

  mem_dump_reader #(.ADDR_W(32), .DATA_W(32), .MAX_BYTES(MAX_B), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(ADC_CLK_10), .rst(rst[1]), .start(start[1]), .start_addr(start_addr[1]),
    .bus(bus_b.master), .busy(busy[1]), .done(done[1]), .byte_count(cnt_b));

  // Memories return garbage except in the one cycle the read data is due.
  always @(posedge ADC_CLK_10) rdata_a <= rd_en[0] ? mem[0][maddr[0][7:0]] : $urandom;
  always @(posedge ADC_CLK_10) begin
    pipe_b[0] <= rd_en[1] ? mem[1][maddr[1][7:0]] : $urandom;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int id);
    return $sformatf("%s_%s", (id == 0) ? "a" : "b", s);
  endfunction

  function automatic int max_of(input int id);
    return (id == 0) ? MAX_A : MAX_B;
  endfunction

  function automatic int lat_of(input int id);
    return (id == 0) ? LAT_A : LAT_B;
  endfunction

  // Reference: walk bytes from the start word, stop at the limit or (optionally) a NUL.
  logic [7:0] exp_b [64];
  int         exp_n;
  function automatic void model(input int id, input logic [31:0] sa);
    logic [31:0] a, w;
    logic [7:0]  b;
    exp_n = 0;
    for (int i = 0; i < max_of(id); i++) begin
      a = sa + 32'(i / 4);
      w = mem[id][a[7:0]];
      b = 8'(w >> (8 * (i % 4)));
      exp_b[i] = b;
      exp_n = i + 1;
      if (NUL_EN && b == 8'h00) break;
    end
  endfunction

  int mode  [2] = '{0, 0};
  int phase [2] = '{0, 0};
  initial begin
    ready = 2'b11;
    forever begin
      @(posedge ADC_CLK_10); #1;
      for (int i = 0; i < 2; i++) begin
        phase[i]++;
        case (mode[i])
          1:       ready[i] = (phase[i] % 4 == 0) || (phase[i] % 4 == 3);
          2:       ready[i] = 1'($urandom_range(0, 1));
          default: ready[i] = 1'b1;
        endcase
      end
    end
  end

  logic [7:0]  obs [2][64];
  logic [31:0] rda [2][64];
  int obs_n [2] = '{0, 0};
  int rd_n  [2] = '{0, 0};
  int first_rd  [2] = '{-1, -1};
  int first_val [2] = '{-1, -1};
  int last_x    [2] = '{-1, -1};
  int done_rise [2] = '{-1, -1};
  logic [1:0] stall_p = 2'b00;
  logic [1:0] done_prev = 2'b00;
  logic [7:0] stall_b [2];

  initial begin
    forever begin
      @(negedge ADC_CLK_10);
      for (int i = 0; i < 2; i++) begin
        if (stall_p[i]) begin
          check_val(tg("stall_valid", i), {31'd0, valid[i]}, 32'd1);
          check_val(tg("stall_data", i), {24'd0, bdata[i]}, {24'd0, stall_b[i]});
        end
        stall_p[i] = valid[i] && !ready[i];
        stall_b[i] = bdata[i];
        if (rd_en[i]) begin
          if (rd_n[i] < 64) rda[i][rd_n[i]] = maddr[i];
          rd_n[i]++;
          if (first_rd[i] < 0) first_rd[i] = cyc;
        end
        if (valid[i] && first_val[i] < 0) first_val[i] = cyc;
        if (valid[i] && ready[i]) begin
          if (obs_n[i] < 64) obs[i][obs_n[i]] = bdata[i];
          obs_n[i]++;
          last_x[i] = cyc;
        end
        if (done[i] && !done_prev[i] && done_rise[i] < 0) done_rise[i] = cyc;
        done_prev[i] = done[i];
      end
    end
  end

  task automatic clear_mon(input int id);
    obs_n[id] = 0; rd_n[id] = 0;
    first_rd[id] = -1; first_val[id] = -1; last_x[id] = -1; done_rise[id] = -1;
  endtask

  task automatic run_dump(input int id, input logic [31:0] sa, input int rmode, input bit poke);
    int n0, k;
    mode[id] = rmode;
    clear_mon(id);
    model(id, sa);
    @(posedge ADC_CLK_10); #1;
    start[id] = 1'b1;
    start_addr[id] = sa;
    @(posedge ADC_CLK_10); #1;
    n0 = cyc;
    start[id] = 1'b0;
    start_addr[id] = ~sa;
    check_val(tg("busy_on", id), {31'd0, busy[id]}, 32'd1);
    check_val(tg("done_clr", id), {31'd0, done[id]}, 32'd0);
    check_val(tg("count_clr", id), bcount[id], 32'd0);
    if (poke) begin
      @(posedge ADC_CLK_10); #1;
      start[id] = 1'b1;
      start_addr[id] = sa + 32'h80;
      @(posedge ADC_CLK_10); #1;
      start[id] = 1'b0;
    end
    k = 0;
    while (!done[id] && k < 3000) begin
      @(negedge ADC_CLK_10);
      k++;
    end
    check_val(tg("done_seen", id), {31'd0, done[id]}, 32'd1);
    repeat (3) @(negedge ADC_CLK_10);
    check_val(tg("nbytes", id), 32'(obs_n[id]), 32'(exp_n));
    for (int i = 0; i < exp_n && i < obs_n[id] && i < 64; i++)
      check_val(tg($sformatf("byte%0d", i), id), {24'd0, obs[id][i]}, {24'd0, exp_b[i]});
    check_val(tg("byte_count", id), bcount[id], 32'(exp_n));
    check_val(tg("busy_end", id), {31'd0, busy[id]}, 32'd0);
    check_val(tg("done_end", id), {31'd0, done[id]}, 32'd1);
    check_val(tg("valid_end", id), {31'd0, valid[id]}, 32'd0);
    check_val(tg("nreads", id), 32'(rd_n[id]), 32'((exp_n + 3) / 4));
    for (int i = 0; i < rd_n[id] && i < 64; i++)
      check_val(tg($sformatf("raddr%0d", i), id), rda[id][i], sa + 32'(i));
    check_val(tg("rd_lat", id), 32'(first_rd[id] - n0), 32'd0);
    check_val(tg("valid_lat", id), 32'(first_val[id] - n0), 32'(1 + lat_of(id)));
    check_val(tg("done_lat", id), 32'(done_rise[id] - last_x[id]), 32'd1);
  endtask

  task automatic check_reset_state(input int id);
    check_val(tg("rst_valid", id), {31'd0, valid[id]}, 32'd0);
    check_val(tg("rst_rd_en", id), {31'd0, rd_en[id]}, 32'd0);
    check_val(tg("rst_busy", id), {31'd0, busy[id]}, 32'd0);
    check_val(tg("rst_done", id), {31'd0, done[id]}, 32'd0);
    check_val(tg("rst_addr", id), maddr[id], 32'd0);
    check_val(tg("rst_data", id), {24'd0, bdata[id]}, 32'd0);
    check_val(tg("rst_count", id), bcount[id], 32'd0);
  endtask

  task automatic reset_mid_dump();
    int k;
    mode[0] = 0;
    clear_mon(0);
    @(posedge ADC_CLK_10); #1;
    start[0] = 1'b1;
    start_addr[0] = 32'h10;
    @(posedge ADC_CLK_10); #1;
    start[0] = 1'b0;
    k = 0;
    do begin
      @(negedge ADC_CLK_10); #1;
      k++;
    end while (obs_n[0] < 3 && k < 100);
    check_val("a_reach_lane2", 32'(obs_n[0]), 32'd3);
    rst[0] = 1'b0;
    #1;
    check_reset_state(0);
    repeat (2) @(negedge ADC_CLK_10);
    rst[0] = 1'b1;
    run_dump(0, 32'h20, 0, 1'b0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int l = 0; l < 4; l++)
      w[8*l +: 8] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return w;
  endfunction

  initial begin
    int id;
    logic [31:0] sa;
    rst = 2'b00;
    start = 2'b00;
    start_addr[0] = '0;
    start_addr[1] = '0;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = rand_word();
      mem[1][i] = rand_word();
    end
    repeat (3) @(negedge ADC_CLK_10);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    rst = 2'b11;

    // String dump, then the same string under 1-0-0-1 backpressure
    mem[0][8'h10] = 32'h6C6C6548;
    mem[0][8'h11] = 32'h0000216F;
    mem[0][8'h12] = 32'h44434241;
    run_dump(0, 32'h10, 0, 1'b0);
    run_dump(0, 32'h10, 1, 1'b0);

    // Length limit on six bytes with a three-cycle memory
    for (int i = 0; i < 256; i++) mem[1][i] = 32'h41414141;
    run_dump(1, 32'h05, 0, 1'b0);

    // Start pulse during WAIT must not redirect the dump
    mem[1][8'h30] = 32'h6C6C6548;
    mem[1][8'h31] = 32'h0000216F;
    run_dump(1, 32'h30, 0, 1'b1);

    reset_mid_dump();

    for (int t = 0; t < 10; t++) begin
      id = t % 2;
      for (int i = 0; i < 256; i++) mem[id][i] = rand_word();
      sa = (t == 3) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
      run_dump(id, sa, int'($urandom_range(0, 2)), t == 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Upstream feeder for the byte-stream output buffer on the board interface. On a start pulse it reads data memory through the second (host) port from a start address, unpacks each 32-bit word into bytes and hands them downstream over a valid/ready byte stream. It stops after a NUL byte or after `MAX_BYTES` bytes. It is the block that drives the memory's second address bus, so a CPU-written string can be dumped to the Arduino pins.

## Interface
Parameters:
- `ADDR_W`, 32: memory address width (word address).
- `DATA_W`, 32: memory word width; fixed at 32, four bytes per word.
- `MAX_BYTES`, 1024: hard limit on bytes emitted per dump.
- `MEM_LATENCY`, 1: cycles from `mem_rd_en` to valid `mem_rdata`; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle request; sampled only in IDLE or DONE.
- `start_addr`, in, `ADDR_W`: first word address; latched on accepted `start`.
- `mem_addr`, out, `ADDR_W`: word address to memory port 2.
- `mem_rd_en`, out, 1: read strobe, one cycle per word.
- `mem_rdata`, in, `DATA_W`: read data, valid `MEM_LATENCY` cycles after the strobe.
- `byte_data`, out, 8: current byte.
- `byte_valid`, out, 1: `byte_data` is valid.
- `byte_ready`, in, 1: downstream accepts; a transfer occurs when valid and ready are both high on a rising edge.
- `busy`, out, 1: high from the accepted `start` until the final byte transfers.
- `done`, out, 1: high from the cycle after the final transfer until the next accepted `start`.
- `byte_count`, out, `$clog2(MAX_BYTES+1)`: bytes transferred in the current or last dump.

## Operation
- FSM states: IDLE, REQ, WAIT, EMIT, DONE.
- **IDLE/DONE → REQ** on `start`. In the same edge:
  - latch `start_addr` into the address register;
  - clear `byte_count`, set `busy`, clear `done`.
- **REQ:**
  - `mem_rd_en=1` for exactly one cycle, with `mem_addr` = address register.
  - Go to WAIT; the latency counter is loaded with `MEM_LATENCY-1`.
- **WAIT:**
  - Count down.
  - At 0, capture `mem_rdata` into the word register and go to EMIT with byte lane 0.
- **EMIT:**
  - `byte_data` = lane k of the word register, little-endian (lane 0 = bits [7:0], lane 3 = bits [31:24]); `byte_valid=1`.
  - On each transfer, `byte_count` increments.
  - Terminate if the transferred byte is 0x00 (the NUL is itself emitted) or `byte_count` reaches `MAX_BYTES`. Terminate means: go to DONE, clear `busy`, set `done`.
  - Otherwise, after lane 3 transfers: increment the address register by 1 (wraps modulo 2^`ADDR_W`) and go to REQ. After any other lane, advance the lane.
- `byte_valid` holds and `byte_data` stays stable while `byte_ready=0`. No byte is dropped or duplicated.
- `start` in REQ/WAIT/EMIT is ignored.
- A NUL transfer and the `MAX_BYTES` limit on the same transfer count as a single termination; `byte_count` = `MAX_BYTES`.
- Reset (any state, asynchronous) forces:
  - IDLE, `busy=0`, `done=0`, `byte_valid=0`, `mem_rd_en=0`;
  - `mem_addr=0`, `byte_data=0`, `byte_count=0`.
- A reset mid-dump abandons the remaining bytes. An in-flight memory read is discarded.

## Timing
- Accepted `start` at edge N: `mem_rd_en` is high in cycle N+1.
- First `byte_valid` is high in cycle N+2+`MEM_LATENCY`.
- Per word with ready held high: 1 (REQ) + `MEM_LATENCY` (WAIT) + 4 (EMIT) cycles. The minimum is 6 cycles per word at `MEM_LATENCY=1`.
- `done` rises on the edge after the final transfer. `busy` falls on that same edge.
- All outputs are registered; there is no combinational path from `byte_ready` or `mem_rdata` to any output.

## Configuration
- `MEM_DUMP_NUL_TERM_EN` defined: a NUL byte terminates the dump, as described above.
- `MEM_DUMP_NUL_TERM_EN` undefined: NUL is an ordinary data byte. Every dump emits exactly `MAX_BYTES` bytes, ending mid-word if `MAX_BYTES` is not a multiple of 4.

## Structure
- Shared package (with the other board-interface definitions) holds:
  - FSM state encoding constants (3-bit);
  - `BYTE_W`=8;
  - default `MAX_BYTES` value;
  - the NUL constant.
- One sub-module, `mem_dump_unpack`: a word register plus lane counter with valid/ready on its output and a load strobe input. It reports when its last lane transfers.
- The FSM, address counter and byte counter stay in `mem_dump_reader`.

## Test plan
- **String dump:** memory [0x10]=0x6C6C6548, [0x11]=0x00216F; `start_addr`=0x10, ready held high → bytes 48 65 6C 6C 6F 21 00; `byte_count`=7; `done`=1; exactly 2 `mem_rd_en` pulses.
- **Backpressure:** same memory; `byte_ready` toggled 1-0-0-1 repeating → same 7-byte sequence; `byte_data` stable during every stall; no extra read strobes.
- **Length limit:** `MAX_BYTES`=6, memory all 0x41 → six 0x41 bytes; `done` in the cycle after the sixth transfer; 2 reads; the second word is only half emitted.
- **Latency:** `MEM_LATENCY`=3 → first `byte_valid` at cycle N+5 after `start` at edge N; data correct.
- **Reset mid-dump:** `rst` low during EMIT lane 2 → all outputs at reset values immediately. A new `start` to 0x20 then produces a clean dump from 0x20.
- **Ignored start / macro off:** a `start` pulse during WAIT is ignored. With `MEM_DUMP_NUL_TERM_EN` undefined and `MAX_BYTES`=8, the string memory yields 8 bytes including 00 and the byte after it.
